adder_ring_counter: RTL and testbench

- Measurement stage directly downstream of the instrumented ripple adder.
- It enables the adder's ring-oscillator loop and counts rising edges of the adder's chain output over a programmable window of wb_clk_i cycles.
- The final count goes to the logic-analyser readback path.
- A count-per-window result lets software derive the adder's carry-chain propagation delay.

---
 rtl/adder_meas_pkg.sv | 24 ++
 rtl/adder_ring_counter_sync_edge_detect.sv | 28 ++
 rtl/adder_ring_counter.sv | 151 +++++++++++++++
 tb/tb_adder_ring_counter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_meas_pkg.sv
// Shared types, default parameters and helpers for the adder ring-oscillator
// measurement stage.
package adder_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } meas_state_e;

  localparam int DEF_COUNT_W     = 32;
  localparam int DEF_WINDOW_W    = 24;
  localparam int DEF_SETTLE      = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // True when the low 'width' bits of cnt are all ones and every bit above is zero.
  function automatic logic count_saturated(input logic [63:0] cnt, input int width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (cnt == max_val);
  endfunction

endpackage

// File: rtl/adder_ring_counter_sync_edge_detect.sv
// Multi-flop synchronizer for the asynchronous ring output followed by a
// single-cycle rising-edge pulse generator.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic ring_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one flop of history on the synchronized level.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ring_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/adder_ring_counter.sv
// Ring-oscillator measurement stage: closes the adder loop for a programmable
// window and counts synchronized rising edges of the chain output.
module adder_ring_counter
  import adder_meas_pkg::*;
#(
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int WINDOW_W    = DEF_WINDOW_W,
  parameter int SETTLE      = DEF_SETTLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                ring_in,
  output logic                ring_enable,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [WINDOW_W-1:0] WIN_ZERO    = {WINDOW_W{1'b0}};
  localparam logic [WINDOW_W-1:0] WIN_ONE     = WINDOW_W'(1);
  localparam logic [COUNT_W-1:0]  CNT_ZERO    = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0]  CNT_ONE     = COUNT_W'(1);

  meas_state_e         state_r, state_s;
  logic [WINDOW_W-1:0] win_r, win_s;
  logic [SETTLE_W-1:0] settle_r, settle_s;
  logic [COUNT_W-1:0]  count_r, count_s;
  logic                ovf_r, ovf_s;
  logic                done_r, done_s;
  logic                en_r, en_s;
  logic                edge_s;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .wb_clk_i   (wb_clk_i),
    .rst_n      (rst_n),
    .ring_in    (ring_in),
    .edge_pulse (edge_s)
  );

  // Next-state logic for the FSM, window/settle down-counters and edge counter.
  always_comb begin
    state_s  = state_r;
    win_s    = win_r;
    settle_s = settle_r;
    count_s  = count_r;
    ovf_s    = ovf_r;
    done_s   = done_r;
    en_s     = en_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_s = ST_IDLE;
          done_s  = 1'b0;
          en_s    = 1'b0;
        end else if (start) begin
          win_s    = window_len;
          settle_s = SETTLE_LOAD;
          count_s  = CNT_ZERO;
          ovf_s    = 1'b0;
          if (window_len == WIN_ZERO) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            en_s    = 1'b0;
          end else begin
            state_s = ST_ARM;
            done_s  = 1'b0;
            en_s    = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_s = ST_IDLE;
          en_s    = 1'b0;
        end else if (settle_r == SETTLE_ZERO) begin
          state_s = ST_COUNT;
        end else begin
          settle_s = settle_r - SETTLE_ONE;
        end
      end
      ST_COUNT: begin
        // The edge seen in the cycle that ends the run (final cycle or abort) still counts.
        if (edge_s) begin
          if (count_saturated(64'(count_r), COUNT_W)) begin
            ovf_s = 1'b1;
          end else begin
            count_s = count_r + CNT_ONE;
          end
        end else begin
          count_s = count_r;
        end
        if (abort) begin
          state_s = ST_IDLE;
          en_s    = 1'b0;
        end else if (win_r == WIN_ONE) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          en_s    = 1'b0;
        end else begin
          win_s = win_r - WIN_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        done_s  = 1'b0;
        en_s    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      win_r    <= WIN_ZERO;
      settle_r <= SETTLE_ZERO;
      count_r  <= CNT_ZERO;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
      en_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      win_r    <= win_s;
      settle_r <= settle_s;
      count_r  <= count_s;
      ovf_r    <= ovf_s;
      done_r   <= done_s;
      en_r     <= en_s;
    end
  end

  assign ring_enable = en_r;
  assign busy        = en_r;
  assign done        = done_r;
  assign count       = count_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_adder_ring_counter.sv
// Self-checking bench: two instances (32-bit and 4-bit counters) share stimulus;
// expected counts come from a delayed rising-transition count of the ring history.
module tb_adder_ring_counter;

  localparam int SETTLE = 4;
  localparam int SYNC   = 2;
  localparam int MAXC   = 20000;

  logic        wb_clk_i = 1'b0;
  logic        rst_n, start, abort, ring_in;
  logic [23:0] window_len;
  logic        ring_enable, busy, done, overflow;
  logic [31:0] count;
  logic        s_ring_enable, s_busy, s_done, s_overflow;
  logic [3:0]  s_count;

  int checks, errors, cyc;
  bit ring_hist [MAXC];
  int ring_mode, ring_period, ring_phase;
  bit ring_level;
  int last_exp;

  adder_ring_counter #(.COUNT_W(32), .WINDOW_W(24), .SETTLE(SETTLE), .SYNC_STAGES(SYNC)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
    .ring_in(ring_in), .ring_enable(ring_enable), .busy(busy), .done(done), .count(count),
    .overflow(overflow));

  adder_ring_counter #(.COUNT_W(4), .WINDOW_W(24), .SETTLE(SETTLE), .SYNC_STAGES(SYNC)) dut_small (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
    .ring_in(ring_in), .ring_enable(s_ring_enable), .busy(s_busy), .done(s_done), .count(s_count),
    .overflow(s_overflow));

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic drive_ring();
    if (ring_mode == 0) ring_in = ring_level;
    else if (ring_mode == 1) ring_in = (((cyc + ring_phase) % ring_period) < (ring_period / 2));
    else ring_in = 1'($urandom_range(0, 1));
    if (cyc < MAXC) ring_hist[cyc] = ring_in;
  endtask

  // Advance to just after the next active edge; cyc names the interval now in progress.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    cyc++;
    drive_ring();
  endtask

  // A 0->1 step of ring_in becomes visible to the counter SYNC intervals later.
  function automatic int expected_edges(input int first, input int last);
    int n = 0;
    for (int c = first; c <= last; c++)
      if (c - SYNC - 1 >= 0 && ring_hist[c - SYNC] && !ring_hist[c - SYNC - 1]) n++;
    return n;
  endfunction

  task automatic run_measure(input int w, input bit poke_start);
    int t0, last_k, exp_n, exp_s;
    bit exp_so;
    window_len = 24'(w);
    start = 1'b1;
    abort = 1'b0;
    t0 = cyc;
    tick();
    start = 1'b0;
    window_len = 24'($urandom);
    last_k = (w == 0) ? 0 : SETTLE + w;
    for (int k = 1; k <= last_k; k++) begin
      checks++;
      if (ring_enable !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || s_ring_enable !== 1'b1) begin
        errors++;
        $display("FAIL run_active k=%0d: en=%b busy=%b done=%b s_en=%b, expected en=1 busy=1 done=0",
                 k, ring_enable, busy, done, s_ring_enable);
      end
      start = (poke_start && k == 3);
      if (start) window_len = 24'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0;
    exp_n = (w == 0) ? 0 : expected_edges(t0 + SETTLE + 1, t0 + SETTLE + w);
    exp_s = (exp_n > 15) ? 15 : exp_n;
    exp_so = (exp_n > 15);
    last_exp = exp_n;
    checks++;
    if (done !== 1'b1 || ring_enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_done w=%0d: done=%b en=%b busy=%b, expected done=1 en=0 busy=0",
               w, done, ring_enable, busy);
    end
    checks++;
    if (count !== 32'(exp_n) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL run_count w=%0d: count=%0d ovf=%b, expected count=%0d ovf=0", w, count, overflow, exp_n);
    end
    checks++;
    if (s_count !== 4'(exp_s) || s_overflow !== exp_so || s_done !== 1'b1) begin
      errors++;
      $display("FAIL run_count_small w=%0d: count=%0d ovf=%b done=%b, expected count=%0d ovf=%b done=1",
               w, s_count, s_overflow, s_done, exp_s, exp_so);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ring_mode = 2;
    start = 1'b1;
    window_len = 24'd50;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({ring_enable, busy, done, overflow, s_ring_enable, s_done, s_overflow} !== 7'd0 ||
          count !== 32'd0 || s_count !== 4'd0) begin
        errors++;
        $display("FAIL reset: en=%b busy=%b done=%b ovf=%b count=%0d, expected all zero",
                 ring_enable, busy, done, overflow, count);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_nominal();
    ring_mode = 1;
    ring_period = 4;
    ring_phase = $urandom_range(0, 3);
    tick();
    run_measure(100, 1'b0);
    checks++;
    if (count !== 32'd25) begin
      errors++;
      $display("FAIL nominal_25: count=%0d, expected 25", count);
    end
  endtask

  task automatic test_zero_window();
    run_measure(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ring_enable !== 1'b0 || done !== 1'b1 || count !== 32'd0) begin
        errors++;
        $display("FAIL zero_window_hold: en=%b done=%b count=%0d, expected en=0 done=1 count=0",
                 ring_enable, done, count);
      end
    end
  endtask

  task automatic test_saturation();
    ring_mode = 1;
    ring_period = 2;
    ring_phase = 0;
    tick();
    run_measure(40, 1'b0);
    checks++;
    if (s_count !== 4'd15 || s_overflow !== 1'b1 || count !== 32'd20) begin
      errors++;
      $display("FAIL saturation: small=%0d ovf=%b big=%0d, expected small=15 ovf=1 big=20",
               s_count, s_overflow, count);
    end
    ring_mode = 0;
    ring_level = 1'b1;
    run_measure(40, 1'b0);
    checks++;
    if (s_count !== 4'd0 || s_overflow !== 1'b0) begin
      errors++;
      $display("FAIL saturation_restart: small=%0d ovf=%b, expected 0 and 0", s_count, s_overflow);
    end
  endtask

  task automatic test_abort();
    int t0, exp_n;
    logic [31:0] held;
    ring_mode = 1;
    ring_period = 4;
    ring_phase = $urandom_range(0, 3);
    window_len = 24'd100;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc < t0 + 20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_n = expected_edges(t0 + SETTLE + 1, t0 + 20);
    checks++;
    if (ring_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 32'(exp_n)) begin
      errors++;
      $display("FAIL abort_count: en=%b busy=%b done=%b count=%0d, expected 0 0 0 count=%0d",
               ring_enable, busy, done, count, exp_n);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done !== 1'b0 || ring_enable !== 1'b0 || count !== 32'(exp_n)) begin
      errors++;
      $display("FAIL abort_idle_hold: done=%b en=%b count=%0d, expected 0 0 %0d", done, ring_enable, count, exp_n);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 32'(exp_n)) begin
      errors++;
      $display("FAIL abort_in_idle: done=%b busy=%b count=%0d, expected 0 0 %0d", done, busy, count, exp_n);
    end
    run_measure(12, 1'b0);
    held = 32'(last_exp);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ring_enable !== 1'b0 || count !== held) begin
        errors++;
        $display("FAIL abort_start_in_done: done=%b busy=%b en=%b count=%0d, expected 0 0 0 %0d",
                 done, busy, ring_enable, count, held);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_random();
    for (int r = 0; r < 8; r++) begin
      ring_mode = $urandom_range(1, 2);
      ring_period = $urandom_range(2, 8);
      ring_phase = $urandom_range(0, 7);
      run_measure($urandom_range(1, 60), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async_reset();
    int t0;
    ring_mode = 1;
    ring_period = 4;
    window_len = 24'd100;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc < t0 + 30) tick();
    #2;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ring_enable, busy, done, overflow, s_ring_enable} !== 5'd0 || count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b busy=%b done=%b ovf=%b count=%0d, expected all zero",
               ring_enable, busy, done, overflow, count);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ring_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 32'd0) begin
        errors++;
        $display("FAIL post_reset_idle: en=%b busy=%b done=%b count=%0d, expected 0 0 0 0",
                 ring_enable, busy, done, count);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    window_len = 24'd0;
    ring_in = 1'b0;
    ring_mode = 0;
    ring_level = 1'b0;
    ring_period = 2;
    ring_phase = 0;
    last_exp = 0;
    test_reset();
    test_nominal();
    test_zero_window();
    test_saturation();
    test_abort();
    test_back_to_back_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
